// File: rtl/tron_player_engine_if.sv
// Pixel plot stream from tron_player_engine to the VGA adapter.
// Master drives the pixel and valid; slave returns ready.
interface tron_player_engine_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           plot_valid;
  logic           plot_ready;
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic [2:0]     plot_colour;

  modport master (
    output plot_valid,
    output plot_x,
    output plot_y,
    output plot_colour,
    input  plot_ready
  );

  modport slave (
    input  plot_valid,
    input  plot_x,
    input  plot_y,
    input  plot_colour,
    output plot_ready
  );
endinterface

// File: rtl/tron_player_engine.sv
// Multi-player Tron engine: directions, moves, crashes, pixel stream.
// Define TRON_WRAP_EN to wrap at the screen edges instead of crashing.
module tron_player_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter logic [NUM_PLAYERS*X_W-1:0] START_X = {8'd100, 8'd25},
  parameter logic [NUM_PLAYERS*Y_W-1:0] START_Y = {7'd100, 7'd25},
  parameter logic [NUM_PLAYERS*2-1:0]   START_DIR = {2'd2, 2'd0},
  parameter logic [NUM_PLAYERS*3-1:0]   COLOURS = {3'b100, 3'b001}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     move_tick,
  input  logic [4*NUM_PLAYERS-1:0] dir_req,
  tron_player_engine_if.master     plot,
  output logic [NUM_PLAYERS-1:0]   alive,
  output logic                     game_over,
  output logic                     tick_overrun
);

`ifdef TRON_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam int IW = $clog2(NUM_PLAYERS + 1);
  localparam logic [X_W-1:0] XM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAW,
    S_OVER
  } state_t;

  state_t                 r_state;
  logic [X_W-1:0]         r_x   [NUM_PLAYERS];
  logic [Y_W-1:0]         r_y   [NUM_PLAYERS];
  logic [1:0]             r_dir [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_alive;
  logic                   r_game_over;
  logic                   r_overrun;
  logic                   r_pending;
  logic [IW-1:0]          r_idx;
  logic                   r_valid;
  logic [X_W-1:0]         r_px;
  logic [Y_W-1:0]         r_py;
  logic [2:0]             r_pc;

  logic [1:0]             w_ndir [NUM_PLAYERS];
  logic [X_W-1:0]         w_nx   [NUM_PLAYERS];
  logic [Y_W-1:0]         w_ny   [NUM_PLAYERS];
  logic [X_W-1:0]         w_px   [NUM_PLAYERS];
  logic [Y_W-1:0]         w_py   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_oob;
  logic [NUM_PLAYERS-1:0] w_crash;
  logic [NUM_PLAYERS-1:0] w_nalive;
  logic                   w_over;

  logic [IW-1:0]          w_start;
  logic                   w_found;
  logic [IW-1:0]          w_sel;
  logic [X_W-1:0]         w_sx;
  logic [Y_W-1:0]         w_sy;
  logic [2:0]             w_sc;
  logic                   w_load;

  // Next direction, next position and crash flags for every player.
  always_comb begin : c_step
    logic [3:0] v_req;
    logic [1:0] v_rd;
    logic       v_one;
    int         v_cnt;
    v_cnt = 0;
    w_crash = '0;
    w_nalive = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      v_req = dir_req[4*i +: 4];
      v_one = (v_req != 4'd0) &&
              ((v_req & (v_req - 4'd1)) == 4'd0);
      v_rd = r_dir[i];
      if (v_one) begin
        unique case (1'b1)
          v_req[0]: v_rd = 2'd1;
          v_req[1]: v_rd = 2'd2;
          v_req[2]: v_rd = 2'd0;
          v_req[3]: v_rd = 2'd3;
        endcase
      end
      w_ndir[i] = r_dir[i];
      if (r_alive[i] && v_one &&
          (v_rd != (r_dir[i] ^ 2'd2)))
        w_ndir[i] = v_rd;
      w_nx[i] = r_x[i];
      w_ny[i] = r_y[i];
      w_oob[i] = 1'b0;
      unique case (w_ndir[i])
        2'd0: begin
          if (r_y[i] >= YM) begin
            w_ny[i] = '0;
            w_oob[i] = !WRAP;
          end else
            w_ny[i] = r_y[i] + 1'b1;
        end
        2'd1: begin
          if (r_x[i] >= XM) begin
            w_nx[i] = '0;
            w_oob[i] = !WRAP;
          end else
            w_nx[i] = r_x[i] + 1'b1;
        end
        2'd2: begin
          if (r_y[i] == '0) begin
            w_ny[i] = YM;
            w_oob[i] = !WRAP;
          end else
            w_ny[i] = r_y[i] - 1'b1;
        end
        2'd3: begin
          if (r_x[i] == '0) begin
            w_nx[i] = XM;
            w_oob[i] = !WRAP;
          end else
            w_nx[i] = r_x[i] - 1'b1;
        end
      endcase
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_crash[i] = r_alive[i] & w_oob[i];
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (i != j && r_alive[i] && r_alive[j] &&
            !w_oob[i] && !w_oob[j] &&
            w_nx[i] == w_nx[j] && w_ny[i] == w_ny[j])
          w_crash[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_nalive[i] = r_alive[i] & ~w_crash[i];
      w_px[i] = w_nalive[i] ? w_nx[i] : r_x[i];
      w_py[i] = w_nalive[i] ? w_ny[i] : r_y[i];
      if (w_nalive[i])
        v_cnt = v_cnt + 1;
    end
    w_over = (v_cnt <= 1);
  end

  // Lowest alive player at or after the draw index; STEP looks ahead.
  assign w_start = (r_state == S_DRAW) ? r_idx : '0;

  always_comb begin : c_sel
    w_found = 1'b0;
    w_sel = '0;
    w_sx = '0;
    w_sy = '0;
    w_sc = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (((r_state == S_STEP) ? w_nalive[i] : r_alive[i]) &&
          (IW'(i) >= w_start)) begin
        w_found = 1'b1;
        w_sel = IW'(i);
        w_sx = (r_state == S_STEP) ? w_px[i] : r_x[i];
        w_sy = (r_state == S_STEP) ? w_py[i] : r_y[i];
        w_sc = COLOURS[3*i +: 3];
      end
    end
  end

  assign w_load = (r_state == S_IDLE && go) ||
                  (r_state == S_STEP) ||
                  (r_state == S_DRAW &&
                   (!r_valid || plot.plot_ready));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_x[i] <= START_X[i*X_W +: X_W];
        r_y[i] <= START_Y[i*Y_W +: Y_W];
        r_dir[i] <= START_DIR[i*2 +: 2];
      end
      r_alive <= '1;
      r_game_over <= 1'b0;
      r_overrun <= 1'b0;
      r_pending <= 1'b0;
      r_idx <= '0;
      r_valid <= 1'b0;
      r_px <= '0;
      r_py <= '0;
      r_pc <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (go)
            r_state <= S_DRAW;
        end
        S_RUN: begin
          if (move_tick || r_pending)
            r_state <= S_STEP;
        end
        S_STEP: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            r_x[i] <= w_px[i];
            r_y[i] <= w_py[i];
            r_dir[i] <= w_ndir[i];
          end
          r_alive <= w_nalive;
          if (w_over)
            r_game_over <= 1'b1;
          r_state <= S_DRAW;
        end
        S_DRAW: begin
          if (w_load && !w_found)
            r_state <= r_game_over ? S_OVER : S_RUN;
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_load) begin
        r_valid <= w_found;
        r_idx <= w_sel + 1'b1;
        if (w_found) begin
          r_px <= w_sx;
          r_py <= w_sy;
          r_pc <= w_sc;
        end
      end

      // One-deep tick buffer while busy; a second tick is lost.
      if (r_state == S_RUN)
        r_pending <= r_pending & move_tick;
      else if ((r_state == S_STEP || r_state == S_DRAW) &&
               move_tick) begin
        if (r_pending)
          r_overrun <= 1'b1;
        else
          r_pending <= 1'b1;
      end
    end
  end

  assign plot.plot_valid = r_valid;
  assign plot.plot_x = r_px;
  assign plot.plot_y = r_py;
  assign plot.plot_colour = r_pc;
  assign alive = r_alive;
  assign game_over = r_game_over;
  assign tick_overrun = r_overrun;

endmodule
